axil_cmd_master: RTL and testbench

Synthesizable AXI4-Lite master that turns a simple valid/ready command stream into single-beat AXI4-Lite read and write transactions. It sits directly upstream of the HLS tester core's `s_axi_control` slave and replaces bench-only register poking in hardware builds. Typical traffic is writing kernel arguments (e.g. offset 0x10) and `ap_start`, then polling the control register at offset 0x00. Every command returns one response carrying the slave's RESP code, or a timeout flag if the slave hangs.

---
 rtl/axil_cmd_master.sv | 173 +++++++++++++++++
 tb/tb_axil_cmd_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: cmd -> AW/W/B or AR/R -> rsp; 3 cycles cmd-to-rsp with a zero-wait slave.
// Backpressure: cmd_ready stays low until the response is consumed; rsp fields hold while rsp_ready is low.
module axil_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_0,
  input  logic              sync_rst_0,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] WR_B = 3'd2;
  localparam logic [2:0] RD_A = 3'd3;
  localparam logic [2:0] RD_D = 3'd4;
  localparam logic [2:0] RSP  = 3'd5;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [2:0]       state;
  logic             aw_done;
  logic             w_done;
  logic [CNT_W-1:0] tmo_cnt;

  logic aw_hs;
  logic w_hs;
  logic busy;
  logic tmo_hit;

  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid && m_axi_wready;
  assign busy    = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_D);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TO_VAL);

  always_ff @(posedge clk_0 or negedge sync_rst_0) begin
    if (!sync_rst_0) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      tmo_cnt       <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= 4'b1111;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else if (busy && tmo_hit) begin
      // Abandon the hung slave: pull every handshake line low and report a SLVERR-coded timeout.
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b10;
      rsp_timeout   <= 1'b1;
      rsp_valid     <= 1'b1;
      state         <= RSP;
    end else begin
      if (busy) tmo_cnt <= tmo_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            tmo_cnt   <= '0;
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_bready  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_A;
            end
          end
        end
        WR: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WR_B;
        end
        WR_B: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_A: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_D;
          end
        end
        RD_D: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a delay-configurable AXI4-Lite slave model;
// expected responses are queued at command issue and compared when the DUT hands them over.
module tb_axil_cmd_master;

  logic        clk_0 = 1'b0;
  logic        sync_rst_0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 clk_0 = ~clk_0;

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk_0(clk_0), .sync_rst_0(sync_rst_0),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic        aw_block = 1'b0;
  logic [1:0]  bresp_val = 2'b00;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic        got_aw, got_w, pend_b, pend_r;
  logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
  logic [3:0]  sl_wstrb;
  int          b_count;
  logic [31:0] mem [16];

  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

  assign m_axi_awready = m_axi_awvalid && !aw_block && (aw_wait >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid && (w_wait >= w_dly);
  assign m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
  assign m_axi_bvalid  = pend_b && (b_wait >= b_dly);
  assign m_axi_bresp   = bresp_val;
  assign m_axi_rvalid  = pend_r && (r_wait >= r_dly);
  assign m_axi_rdata   = mem[sl_araddr[5:2]];
  assign m_axi_rresp   = 2'b00;

  always @(posedge clk_0 or negedge sync_rst_0) begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        aw_now, w_now;
    if (!sync_rst_0) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; pend_b <= 1'b0; pend_r <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0; sl_araddr <= '0;
      b_count <= 0;
    end else begin
      if (m_axi_awvalid && !m_axi_awready) aw_wait <= aw_wait + 1;
      if (m_axi_wvalid && !m_axi_wready) w_wait <= w_wait + 1;
      if (m_axi_arvalid && !m_axi_arready) ar_wait <= ar_wait + 1;
      a = (m_axi_awvalid && m_axi_awready) ? m_axi_awaddr : sl_awaddr;
      d = (m_axi_wvalid && m_axi_wready) ? m_axi_wdata : sl_wdata;
      s = (m_axi_wvalid && m_axi_wready) ? m_axi_wstrb : sl_wstrb;
      aw_now = got_aw || (m_axi_awvalid && m_axi_awready);
      w_now  = got_w || (m_axi_wvalid && m_axi_wready);
      if (m_axi_awvalid && m_axi_awready) begin aw_wait <= 0; got_aw <= 1'b1; sl_awaddr <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin w_wait <= 0; got_w <= 1'b1; sl_wdata <= m_axi_wdata; sl_wstrb <= m_axi_wstrb; end
      if (aw_now && w_now && !pend_b) begin
        pend_b <= 1'b1; b_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
        for (int i = 0; i < 4; i++) if (s[i]) mem[a[5:2]][8*i +: 8] <= d[8*i +: 8];
      end
      if (pend_b) begin
        if (m_axi_bvalid && m_axi_bready) begin pend_b <= 1'b0; b_count <= b_count + 1; end
        else b_wait <= b_wait + 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_wait <= 0; pend_r <= 1'b1; r_wait <= 0; sl_araddr <= m_axi_araddr;
      end
      if (pend_r) begin
        if (m_axi_rvalid && m_axi_rready) pend_r <= 1'b0;
        else r_wait <= r_wait + 1;
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } rsp_t;

  rsp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_0) begin
    rsp_t e;
    if (sync_rst_0 && rsp_valid && rsp_ready) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected_rsp observed=0x%0h expected=none", rsp_rdata);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
      end
    end
  end

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  task automatic wait_cmd_ready(input int budget);
    int n = 0;
    while (!cmd_ready && n < budget) begin tick(); n++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin tick(); n++; end
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Drive one command in the current cycle; returns in the cycle after acceptance.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic push, input rsp_t exp);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    if (push) sb_q.push_back(exp);
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input rsp_t exp);
    wait_cmd_ready(50);
    issue(wr, addr, data, strb, 1'b1, exp);
    wait_drain(100);
  endtask

  initial begin
    int b0;
    sync_rst_0 = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    #12;
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_addr_data", {m_axi_awaddr, m_axi_araddr | m_axi_wdata}, 64'd0);
    chk("rst_wstrb", 64'(m_axi_wstrb), 64'hF);
    chk("rst_cmd_rsp", {59'd0, cmd_ready, rsp_valid, rsp_resp, rsp_timeout}, 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    tick(); tick();
    sync_rst_0 = 1'b1;
    chk("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
    tick();
    chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // Zero-wait write: exact cycle timing.
    issue(1'b1, 32'h10, 32'h0000_0E9E, 4'hF, 1'b1, '{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
    chk("c1_aw_w_valid", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd3);
    chk("c1_awaddr", 64'(m_axi_awaddr), 64'h10);
    chk("c1_wdata", 64'(m_axi_wdata), 64'hE9E);
    chk("c1_bready", 64'(m_axi_bready), 64'd1);
    tick();
    chk("c2_valids_low", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd0);
    chk("c2_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("c3_rsp_valid", 64'(rsp_valid), 64'd1);
    tick();
    chk("c4_cmd_ready", 64'(cmd_ready), 64'd1);
    wait_drain(10);

    // W accepted three cycles ahead of AW.
    aw_dly = 3; b0 = b_count;
    issue(1'b1, 32'h08, 32'h1234_5678, 4'hF, 1'b1, '{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
    tick();
    chk("wfirst_c2", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd2);
    tick();
    chk("wfirst_c3", {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd2);
    tick(); tick();
    chk("wfirst_c5_aw_low", 64'(m_axi_awvalid), 64'd0);
    wait_drain(50);
    tick(); tick();
    chk("wfirst_b_count", 64'(b_count - b0), 64'd1);
    aw_dly = 0;

    // Reads, including a 5-cycle R delay and a partial-strobe write.
    do_cmd(1'b1, 32'h00, 32'h0000_0004, 4'hF, '{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
    r_dly = 5;
    do_cmd(1'b0, 32'h00, 32'h0, 4'h0, '{rdata: 32'h4, resp: 2'b00, tmo: 1'b0});
    r_dly = 0;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, '{rdata: 32'hE9E, resp: 2'b00, tmo: 1'b0});
    do_cmd(1'b1, 32'h14, 32'hAABB_CCDD, 4'b0011, '{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
    do_cmd(1'b0, 32'h14, 32'h0, 4'h0, '{rdata: 32'h0000_CCDD, resp: 2'b00, tmo: 1'b0});
    do_cmd(1'b0, 32'h08, 32'h0, 4'h0, '{rdata: 32'h1234_5678, resp: 2'b00, tmo: 1'b0});

    // SLVERR on B passes straight through.
    bresp_val = 2'b10;
    do_cmd(1'b1, 32'h20, 32'h1, 4'hF, '{rdata: 32'h0, resp: 2'b10, tmo: 1'b0});
    bresp_val = 2'b00;

    // Hung AW with TIMEOUT=16.
    aw_block = 1'b1;
    wait_cmd_ready(20);
    issue(1'b1, 32'h1C, 32'h1, 4'hF, 1'b1, '{rdata: 32'h0, resp: 2'b10, tmo: 1'b1});
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_c16_still_waiting", {62'd0, m_axi_awvalid, rsp_valid}, 64'd2);
    tick(); tick();
    chk("tmo_c18_lines_low", {61'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 64'd0);
    chk("tmo_c18_rsp", {62'd0, rsp_valid, rsp_timeout}, 64'd3);
    wait_drain(10);
    aw_block = 1'b0;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, '{rdata: 32'hE9E, resp: 2'b00, tmo: 1'b0});

    // Response backpressure.
    rsp_ready = 1'b0;
    wait_cmd_ready(20);
    issue(1'b0, 32'h00, 32'h0, 4'h0, 1'b1, '{rdata: 32'h4, resp: 2'b00, tmo: 1'b0});
    for (int n = 0; n < 20 && !rsp_valid; n++) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready},
          {1'b1, 32'h4, 2'b00, 1'b0, 1'b0});
      tick();
    end
    rsp_ready = 1'b1;
    wait_drain(10);

    // Reset while waiting for B; no response may appear for the aborted write.
    b_dly = 5;
    wait_cmd_ready(20);
    issue(1'b1, 32'h18, 32'h55, 4'hF, 1'b0, '0);
    tick();
    chk("wrb_bready", {62'd0, m_axi_bready, m_axi_awvalid}, 64'd2);
    #2 sync_rst_0 = 1'b0;
    #1;
    chk("midrst_lines", {59'd0, m_axi_bready, m_axi_awvalid, m_axi_wvalid, cmd_ready, rsp_valid}, 64'd0);
    chk("midrst_addr_data", {m_axi_awaddr, m_axi_wdata}, 64'd0);
    chk("midrst_wstrb", 64'(m_axi_wstrb), 64'hF);
    tick(); tick();
    sync_rst_0 = 1'b1;
    b_dly = 0;
    do_cmd(1'b1, 32'h18, 32'h77, 4'hF, '{rdata: 32'h0, resp: 2'b00, tmo: 1'b0});
    do_cmd(1'b0, 32'h18, 32'h0, 4'h0, '{rdata: 32'h77, resp: 2'b00, tmo: 1'b0});

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
